// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel 3x3 window front end.
package sobel_pkg;

  localparam int PIX_W_DEF      = 8;
  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;

  // Smallest bit count able to index 'value' distinct positions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of delay: read the old value at addr combinationally,
// overwrite it with din on an enabled edge (read-before-write at one column).
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 8,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);

  // Contents are never reset; rows are always rewritten before they are used.
  logic [W-1:0] mem [DEPTH];

  assign dout = mem[addr];

  // Store the incoming pixel at its column when the stream advances.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 sliding window generator over a raster pixel stream. Two cascaded line
// buffers supply the two previous rows; a 3x3 register window shifts left on
// every accepted pixel and done_o flags windows lying fully inside the image.
//
// Stream handshake: pix_i/sof_i are consumed on every rising edge where
// pix_valid_i=1; there is no ready, the block always accepts. done_o and
// frame_done_o are single-cycle strobes, never held, never backpressured.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int PIX_W      = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_i,
  input  logic             pix_valid_i,
  input  logic             sof_i,
  output logic [PIX_W-1:0] d0_o,
  output logic [PIX_W-1:0] d1_o,
  output logic [PIX_W-1:0] d2_o,
  output logic [PIX_W-1:0] d3_o,
  output logic [PIX_W-1:0] d4_o,
  output logic [PIX_W-1:0] d5_o,
  output logic [PIX_W-1:0] d6_o,
  output logic [PIX_W-1:0] d7_o,
  output logic [PIX_W-1:0] d8_o,
  output logic             done_o,
  output logic             frame_done_o
);

  localparam int XW = clog2(IMG_WIDTH);
  localparam int YW = clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0]    x_q, cur_x, x_nxt;
  logic [YW-1:0]    y_q, cur_y, y_nxt;
  logic             x_last, y_last, interior;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] win_q [9];

  // Coordinate of the pixel on this edge; sof forces (0,0) regardless of counters.
  always_comb begin
    cur_x    = sof_i ? '0 : x_q;
    cur_y    = sof_i ? '0 : y_q;
    x_last   = (cur_x == X_LAST);
    y_last   = (cur_y == Y_LAST);
    interior = (cur_x >= XW'(2)) && (cur_y >= YW'(2));
    x_nxt    = x_last ? '0 : cur_x + XW'(1);
    y_nxt    = cur_y;
    if (x_last) begin
      y_nxt = y_last ? '0 : cur_y + YW'(1);
    end
  end

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W), .AW(XW)) u_lb0 (
    .clk  (clk),
    .en   (pix_valid_i),
    .addr (cur_x),
    .din  (pix_i),
    .dout (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W), .AW(XW)) u_lb1 (
    .clk  (clk),
    .en   (pix_valid_i),
    .addr (cur_x),
    .din  (lb0_rd),
    .dout (lb1_rd)
  );

  // Raster counters advance only on accepted pixels and wrap at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pix_valid_i) begin
      x_q <= x_nxt;
      y_q <= y_nxt;
    end
  end

  // Window shifts left; right column is {two rows up, one row up, current pixel}.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else if (pix_valid_i) begin
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= lb1_rd;
      win_q[3] <= win_q[4];
      win_q[4] <= win_q[5];
      win_q[5] <= lb0_rd;
      win_q[6] <= win_q[7];
      win_q[7] <= win_q[8];
      win_q[8] <= pix_i;
    end
  end

  // Strobes: window valid for interior pixels, frame end on the last position.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      done_o       <= pix_valid_i && interior;
      frame_done_o <= pix_valid_i && x_last && y_last;
    end
  end

  assign d0_o = win_q[0];
  assign d1_o = win_q[1];
  assign d2_o = win_q[2];
  assign d3_o = win_q[3];
  assign d4_o = win_q[4];
  assign d5_o = win_q[5];
  assign d6_o = win_q[6];
  assign d7_o = win_q[7];
  assign d8_o = win_q[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 5x4 image: an image-coordinate model builds
// the expected 3x3 neighbourhood per accepted pixel; directed frames add
// literal tap and strobe-count checks.
module tb_sobel_window_gen;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pix_i;
  logic          pix_valid_i;
  logic          sof_i;
  logic [PW-1:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
  logic          done_o;
  logic          frame_done_o;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_i        (pix_i),
    .pix_valid_i  (pix_valid_i),
    .sof_i        (sof_i),
    .d0_o         (d0_o),
    .d1_o         (d1_o),
    .d2_o         (d2_o),
    .d3_o         (d3_o),
    .d4_o         (d4_o),
    .d5_o         (d5_o),
    .d6_o         (d6_o),
    .d7_o         (d7_o),
    .d8_o         (d8_o),
    .done_o       (done_o),
    .frame_done_o (frame_done_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] tap(input int i);
    case (i)
      0: return d0_o;
      1: return d1_o;
      2: return d2_o;
      3: return d3_o;
      4: return d4_o;
      5: return d5_o;
      6: return d6_o;
      7: return d7_o;
      default: return d8_o;
    endcase
  endfunction

  // ---------------- model ----------------
  // Remembers the frame as an image; on every accepted pixel at (x,y) with a
  // full 3x3 neighbourhood, the expected window is image rows y-2..y, cols x-2..x.
  logic [PW-1:0] img [H][W];
  int            mx = 0;
  int            my = 0;
  logic          exp_done = 1'b0;
  logic          exp_fd   = 1'b0;
  logic [PW-1:0] exp_win [9];
  bit            check_en = 1'b0;
  int            done_cnt = 0;
  int            fd_cnt   = 0;

  always @(posedge clk) begin
    exp_done = 1'b0;
    exp_fd   = 1'b0;
    if (rst) begin
      mx = 0;
      my = 0;
    end else if (pix_valid_i) begin
      if (sof_i) begin
        mx = 0;
        my = 0;
      end
      img[my][mx] = pix_i;
      if (mx >= 2 && my >= 2) begin
        exp_done = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_win[r*3+c] = img[my-2+r][mx-2+c];
      end
      exp_fd = (mx == W-1) && (my == H-1);
      if (mx == W-1) begin
        mx = 0;
        my = (my == H-1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
  end

  // ---------------- scoreboard compare (opposite edge) ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("done_o", 32'(done_o), 32'(exp_done));
      check("frame_done_o", 32'(frame_done_o), 32'(exp_fd));
      if (exp_done) begin
        for (int i = 0; i < 9; i++)
          check($sformatf("tap d%0d", i), 32'(tap(i)), 32'(exp_win[i]));
      end
      if (done_o) done_cnt++;
      if (frame_done_o) fd_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [PW-1:0] p, input logic s);
    pix_i       = p;
    sof_i       = s;
    pix_valid_i = 1'b1;
    @(posedge clk);
    #1;
    pix_valid_i = 1'b0;
    sof_i       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [PW-1:0] pat(input int kind, input int x, input int y);
    if (kind == 0) return PW'(y * 16 + x);
    return (x < 2) ? PW'(0) : PW'(200);
  endfunction

  // Full frame with per-frame count checks; pattern 0 also gets literal taps.
  task automatic run_frame(input int kind, input bit use_sof, input bit gaps, input string tag);
    int c0, f0;
    c0 = done_cnt;
    f0 = fd_cnt;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        send(pat(kind, x, y), use_sof && x == 0 && y == 0);
        if (kind == 0 && x == 2 && y == 2) begin
          check({tag, " first done"}, 32'(done_o), 32'd1);
          check({tag, " first d0"}, 32'(d0_o), 32'h00);
          check({tag, " first d1"}, 32'(d1_o), 32'h01);
          check({tag, " first d2"}, 32'(d2_o), 32'h02);
          check({tag, " first d3"}, 32'(d3_o), 32'h10);
          check({tag, " first d4"}, 32'(d4_o), 32'h11);
          check({tag, " first d5"}, 32'(d5_o), 32'h12);
          check({tag, " first d6"}, 32'(d6_o), 32'h20);
          check({tag, " first d7"}, 32'(d7_o), 32'h21);
          check({tag, " first d8"}, 32'(d8_o), 32'h22);
        end
        if (kind == 1 && x == 2 && y == 2) begin
          check({tag, " edge d0"}, 32'(d0_o), 32'd0);
          check({tag, " edge d2"}, 32'(d2_o), 32'd200);
        end
        if (kind == 0 && x == W-1 && y == H-1) begin
          check({tag, " last d0"}, 32'(d0_o), 32'h12);
          check({tag, " last d4"}, 32'(d4_o), 32'h23);
          check({tag, " last d8"}, 32'(d8_o), 32'h34);
          check({tag, " last frame_done"}, 32'(frame_done_o), 32'd1);
        end
        if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
    end
    idle(1);
    check({tag, " done count"}, 32'(done_cnt - c0), 32'((W-2)*(H-2)));
    check({tag, " frame_done count"}, 32'(fd_cnt - f0), 32'd1);
  endtask

  // Send the first n raster pixels of a pattern-0 frame (sof on the first).
  task automatic partial(input int n);
    for (int i = 0; i < n; i++)
      send(pat(0, i % W, i / W), i == 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0, f0;
    rst = 1'b1; pix_valid_i = 1'b0; sof_i = 1'b0; pix_i = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset done_o", 32'(done_o), 32'd0);
    check("reset frame_done_o", 32'(frame_done_o), 32'd0);
    check("reset d4", 32'(d4_o), 32'd0);
    check("reset d8", 32'(d8_o), 32'd0);
    rst = 1'b0;
    check_en = 1'b1;
    idle(1);

    run_frame(0, 1'b1, 1'b0, "frame1");
    run_frame(0, 1'b0, 1'b0, "frame2 no sof");
    run_frame(0, 1'b1, 1'b1, "gapped");

    // sof at (3,2): abandon the partial frame.
    c0 = done_cnt; f0 = fd_cnt;
    partial(2*W + 3);
    idle(1);
    check("abort done count", 32'(done_cnt - c0), 32'd1);
    check("abort no frame_done", 32'(fd_cnt - f0), 32'd0);
    run_frame(0, 1'b1, 1'b0, "after sof restart");

    // Reset at (4,1), then restart without sof.
    partial(W + 4);
    rst = 1'b1; pix_i = 8'h14; pix_valid_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; pix_valid_i = 1'b0;
    check("midrst done_o", 32'(done_o), 32'd0);
    check("midrst frame_done_o", 32'(frame_done_o), 32'd0);
    for (int i = 0; i < 9; i++)
      check($sformatf("midrst d%0d", i), 32'(tap(i)), 32'd0);
    run_frame(0, 1'b0, 1'b0, "after reset");

    // sof on the final pixel position suppresses the old frame's last window.
    c0 = done_cnt; f0 = fd_cnt;
    partial(W*H - 1);
    idle(1);
    check("sof-at-last done count", 32'(done_cnt - c0), 32'd5);
    run_frame(0, 1'b1, 1'b0, "sof at last");
    check("sof-at-last frame_done count", 32'(fd_cnt - f0), 32'd1);

    // Step-edge image.
    run_frame(1, 1'b1, 1'b0, "edge image");

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
